rx_watchdog_mc: RTL and testbench

Multi-antenna receive watchdog that supervises the OFDM receiver from power trigger until the SIGNAL field is accepted, and forces a receiver reset when the front end is stuck on a false detection. It sits beside the dot11 core in the rx top level, and its output is ORed into the core reset. It generalises the single-channel watchdog to NUM_CH IQ channels with a per-channel mask, a configurable DC window, a header-arrival timeout, a reset cause code and an event counter.

---
 rtl/rx_watchdog_mc.sv | 182 ++++++++++++++++++
 tb/tb_rx_watchdog_mc.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_watchdog_mc.sv
// Multi-channel receive watchdog: supervises the receiver from power trigger to an
// accepted SIGNAL field and pulses a receiver reset on DC, length or header-timeout faults.

module rx_watchdog_mc_lane #(
  parameter int DC_WIN_LOG2 = 4
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       clr,
  input  logic       step,
  input  logic       full,
  input  logic       chk_en,
  input  logic [1:0] neg,
  input  logic [7:0] th,
  output logic       alarm
);
  localparam int W  = 1 << DC_WIN_LOG2;
  localparam int SW = DC_WIN_LOG2 + 3;

  logic signed [2:0]    c;
  logic signed [2:0]    sr [W];
  logic signed [SW-1:0] sum, sum_nxt;
  logic        [SW-1:0] mag;

  // Sign-only contribution: each of I and Q votes +1 or -1.
  always_comb begin
    case (neg)
      2'b00:   c = 3'sd2;
      2'b11:   c = -3'sd2;
      default: c = 3'sd0;
    endcase
  end

  assign sum_nxt = sum + SW'(c) - SW'(sr[W-1]);
  assign mag     = sum_nxt[SW-1] ? $unsigned(-sum_nxt) : $unsigned(sum_nxt);
  assign alarm   = full && chk_en && (th != 8'd0) && ((SW+8)'(mag) >= (SW+8)'(th));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn || clr) begin
      sum <= '0;
      for (int i = 0; i < W; i++) sr[i] <= '0;
    end else if (step) begin
      sum   <= sum_nxt;
      sr[0] <= c;
      for (int i = 1; i < W; i++) sr[i] <= sr[i-1];
    end
  end
endmodule

module rx_watchdog_mc #(
  parameter int NUM_CH        = 2,
  parameter int IQ_DATA_WIDTH = 16,
  parameter int DC_WIN_LOG2   = 4,
  parameter int RST_PULSE_LEN = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rstn,
  input  logic                            i_enable,
  input  logic                            i_power_trigger,
  input  logic [NUM_CH*2*IQ_DATA_WIDTH-1:0] i_iq,
  input  logic                            i_iq_valid,
  input  logic [NUM_CH-1:0]               i_ch_mask,
  input  logic [7:0]                      i_dc_running_sum_th,
  input  logic                            i_sig_valid,
  input  logic [15:0]                     i_signal_len,
  input  logic [15:0]                     i_min_signal_len_th,
  input  logic [15:0]                     i_max_signal_len_th,
  input  logic [15:0]                     i_hdr_timeout_th,
  output logic                            o_receiver_rst,
  output logic [2:0]                      o_rst_cause,
  output logic [NUM_CH-1:0]               o_dc_alarm,
  output logic [CNT_WIDTH-1:0]            o_event_count
);
  localparam int CW = 2 * IQ_DATA_WIDTH;
  localparam int PW = $clog2(RST_PULSE_LEN + 1);
  localparam logic [DC_WIN_LOG2:0] WFULL = (DC_WIN_LOG2+1)'(1) << DC_WIN_LOG2;

  typedef enum logic [1:0] {IDLE, ARMED, PULSE} state_t;
  state_t state, state_nxt;

  logic [PW-1:0]        pcnt;
  logic [DC_WIN_LOG2:0] fill, fill_nxt;
  logic [15:0]          tcnt;
  logic                 hdr_seen;
  logic                 go, clr, act, step, full;
  logic                 len_short, len_long, sig_ok, dc_f, to_f, fault;
  logic [2:0]           cause;
  logic [NUM_CH-1:0]    alarm;
  logic                 unused_iq;

  // The DC check uses only the sign bits of each component.
  assign unused_iq = ^i_iq;

  assign go       = i_enable & i_power_trigger;
  assign clr      = (state == IDLE) & go;
  assign act      = (state == ARMED) & go;
  assign step     = act & i_iq_valid;
  assign fill_nxt = (fill == WFULL) ? fill : fill + 1'b1;
  assign full     = (fill_nxt == WFULL);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    rx_watchdog_mc_lane #(.DC_WIN_LOG2(DC_WIN_LOG2)) u_lane (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .clr    (clr),
      .step   (step),
      .full   (full),
      .chk_en (i_ch_mask[k]),
      .neg    ({i_iq[k*CW + CW - 1], i_iq[k*CW + IQ_DATA_WIDTH - 1]}),
      .th     (i_dc_running_sum_th),
      .alarm  (alarm[k])
    );
  end

  assign len_short = act & i_sig_valid & (i_signal_len < i_min_signal_len_th);
  assign len_long  = act & i_sig_valid & ~len_short & (i_max_signal_len_th != 16'd0) &
                     (i_signal_len > i_max_signal_len_th);
  assign sig_ok    = act & i_sig_valid & ~len_short & ~len_long;
  assign dc_f      = step & (|alarm);
  // A good SIGNAL on the same sample wins over the timeout.
  assign to_f      = step & ~hdr_seen & ~sig_ok & (i_hdr_timeout_th != 16'd0) &
                     (tcnt + 16'd1 == i_hdr_timeout_th);

  always_comb begin
    cause = 3'd0;
    if      (len_short) cause = 3'd2;
    else if (len_long)  cause = 3'd3;
    else if (dc_f)      cause = 3'd1;
    else if (to_f)      cause = 3'd4;
  end
  assign fault = (cause != 3'd0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = ARMED;
      ARMED:   if (!go) state_nxt = IDLE;
               else if (fault) state_nxt = PULSE;
      PULSE:   if (pcnt == PW'(RST_PULSE_LEN - 1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= IDLE;
    else         state <= state_nxt;
  end

  assign o_receiver_rst = (state == PULSE);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pcnt          <= '0;
      fill          <= '0;
      tcnt          <= '0;
      hdr_seen      <= 1'b0;
      o_rst_cause   <= '0;
      o_dc_alarm    <= '0;
      o_event_count <= '0;
    end else begin
      pcnt <= (state == PULSE) ? pcnt + 1'b1 : '0;
      if (clr) begin
        fill       <= '0;
        tcnt       <= '0;
        hdr_seen   <= 1'b0;
        o_dc_alarm <= '0;
      end else begin
        if (step) begin
          fill       <= fill_nxt;
          o_dc_alarm <= alarm;
          if (!hdr_seen) tcnt <= tcnt + 16'd1;
        end
        if (sig_ok) hdr_seen <= 1'b1;
      end
      if (fault) begin
        o_rst_cause <= cause;
        if (~&o_event_count) o_event_count <= o_event_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rx_watchdog_mc.sv
// Directed bench for rx_watchdog_mc: a window/queue model checked every cycle,
// plus literal expectations at the interesting points of each scenario.

module tb_rx_watchdog_mc;
  localparam int NCH = 2, IQW = 16, PLEN = 4, WIN = 16;

  logic clk = 0, rstn = 0, en = 0, trig = 0, iq_valid = 0, sig_valid = 0;
  logic [NCH*2*IQW-1:0] iq = '0;
  logic [NCH-1:0] mask = '1;
  logic [7:0]  dc_th = 0;
  logic [15:0] len = 0, min_th = 0, max_th = 0, to_th = 0;
  logic        rst;
  logic [2:0]  cause;
  logic [NCH-1:0] alarm;
  logic [15:0] cnt;

  rx_watchdog_mc #(.NUM_CH(NCH), .IQ_DATA_WIDTH(IQW), .DC_WIN_LOG2(4),
                   .RST_PULSE_LEN(PLEN), .CNT_WIDTH(16)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(en), .i_power_trigger(trig),
    .i_iq(iq), .i_iq_valid(iq_valid), .i_ch_mask(mask),
    .i_dc_running_sum_th(dc_th), .i_sig_valid(sig_valid), .i_signal_len(len),
    .i_min_signal_len_th(min_th), .i_max_signal_len_th(max_th),
    .i_hdr_timeout_th(to_th), .o_receiver_rst(rst), .o_rst_cause(cause),
    .o_dc_alarm(alarm), .o_event_count(cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sgn(logic [IQW-1:0] x);
    return x[IQW-1] ? -1 : 1;
  endfunction

  // Model: mode 0 idle, 1 armed, 2 pulsing with m_prem clocks left.
  int m_mode, m_prem, m_tc, m_cause, m_cnt;
  bit m_hdr;
  logic [NCH-1:0] m_alarm;
  int win [NCH][$];
  int mk_s, mk_nc;
  bit mk_dc, mk_to, mk_sh, mk_lg, mk_ok;
  logic [NCH-1:0] mk_al;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_mode = 0; m_prem = 0; m_tc = 0; m_cause = 0; m_cnt = 0; m_hdr = 0; m_alarm = 0;
      for (int k = 0; k < NCH; k++) win[k].delete();
    end else begin
      case (m_mode)
        0: if (en && trig) begin
          m_mode = 1; m_alarm = 0; m_tc = 0; m_hdr = 0;
          for (int k = 0; k < NCH; k++) win[k].delete();
        end
        1: if (!(en && trig)) m_mode = 0;
        else begin
          mk_dc = 0; mk_to = 0; mk_sh = 0; mk_lg = 0; mk_ok = 0; mk_al = 0;
          if (iq_valid) begin
            for (int k = 0; k < NCH; k++) begin
              win[k].push_back(sgn(iq[k*2*IQW+IQW +: IQW]) + sgn(iq[k*2*IQW +: IQW]));
              if (win[k].size() > WIN) void'(win[k].pop_front());
              mk_s = 0;
              foreach (win[k][j]) mk_s += win[k][j];
              if (mk_s < 0) mk_s = -mk_s;
              if (win[k].size() == WIN && dc_th != 0 && mk_s >= int'(dc_th) && mask[k])
                mk_al[k] = 1;
            end
            m_alarm = mk_al;
            mk_dc = (mk_al != 0);
          end
          if (sig_valid) begin
            if (len < min_th) mk_sh = 1;
            else if (max_th != 0 && len > max_th) mk_lg = 1;
            else mk_ok = 1;
          end
          if (iq_valid && !m_hdr && !mk_ok) begin
            m_tc++;
            if (to_th != 0 && m_tc == int'(to_th)) mk_to = 1;
          end
          if (mk_ok) m_hdr = 1;
          mk_nc = mk_sh ? 2 : mk_lg ? 3 : mk_dc ? 1 : mk_to ? 4 : 0;
          if (mk_nc != 0) begin
            m_cause = mk_nc;
            if (m_cnt < 65535) m_cnt++;
            m_mode = 2; m_prem = PLEN;
          end
        end
        default: begin
          m_prem--;
          if (m_prem == 0) m_mode = 0;
        end
      endcase
    end
  end

  always @(posedge clk) begin
    #2;
    chk("cyc_rst", rst, int'(m_mode == 2));
    chk("cyc_cause", cause, m_cause);
    chk("cyc_alarm", alarm, m_alarm);
    chk("cyc_count", cnt, m_cnt);
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0; en = 0; trig = 0; iq_valid = 0; sig_valid = 0;
    cyc(2);
    rstn = 1;
    cyc(1);
  endtask

  task automatic arm();
    en = 1; trig = 1;
    cyc(1);
  endtask

  // ch0 constant +100/+100, ch1 alternating sign; optional SIGNAL strobe on sample sig_at.
  task automatic run(int n, int sig_at, int sig_len);
    logic [IQW-1:0] v1;
    for (int i = 1; i <= n; i++) begin
      v1 = (i % 2 == 1) ? 16'd100 : 16'hFF9C;
      iq = {v1, v1, 16'd100, 16'd100};
      iq_valid = 1;
      sig_valid = (i == sig_at);
      len = 16'(sig_len);
      cyc(1);
    end
    iq_valid = 0; sig_valid = 0;
  endtask

  task automatic strobe_len(int l);
    sig_valid = 1; len = 16'(l);
    cyc(1);
    sig_valid = 0;
  endtask

  task automatic pulse_width(string name);
    int h;
    h = 0;
    for (int i = 0; i < 8; i++) begin
      if (rst) h++;
      cyc(1);
    end
    chk(name, h, PLEN);
  endtask

  initial begin
    cyc(1);
    chk("reset_rst", rst, 0);
    chk("reset_cause", cause, 0);
    chk("reset_count", cnt, 0);

    // DC fault on ch0 at the 16th sample
    do_reset(); dc_th = 20; mask = 2'b11; arm();
    run(15, 0, 0);
    chk("dc_before_full", rst, 0);
    run(1, 0, 0);
    chk("dc_rst", rst, 1);
    chk("dc_cause", cause, 1);
    chk("dc_alarm", alarm, 1);
    chk("dc_count", cnt, 1);
    pulse_width("dc_pulse_len");
    chk("dc_cause_held", cause, 1);

    // ch0 masked out
    do_reset(); mask = 2'b10; arm();
    run(20, 0, 0);
    chk("mask_rst", rst, 0);
    chk("mask_alarm", alarm, 0);
    chk("mask_count", cnt, 0);

    // length checks
    do_reset(); dc_th = 0; mask = 2'b11; min_th = 14; max_th = 1600; arm();
    strobe_len(10);
    chk("short_rst", rst, 1);
    chk("short_cause", cause, 2);
    cyc(6);
    strobe_len(2000);
    chk("long_rst", rst, 1);
    chk("long_cause", cause, 3);
    chk("long_count", cnt, 2);
    cyc(6);
    to_th = 5;
    strobe_len(500);
    chk("ok_rst", rst, 0);
    run(10, 0, 0);
    chk("frozen_rst", rst, 0);
    chk("frozen_count", cnt, 2);
    chk("frozen_cause", cause, 3);

    // header timeout
    do_reset(); to_th = 100; arm();
    run(99, 0, 0);
    chk("to_99_rst", rst, 0);
    run(1, 0, 0);
    chk("to_100_rst", rst, 1);
    chk("to_cause", cause, 4);
    cyc(6);
    do_reset(); arm();
    run(120, 50, 500);
    chk("to_hdr_rst", rst, 0);
    chk("to_hdr_count", cnt, 0);

    // simultaneous DC and short length
    do_reset(); to_th = 0; dc_th = 20; arm();
    run(16, 16, 10);
    chk("both_cause", cause, 2);
    chk("both_alarm", alarm, 1);
    chk("both_count", cnt, 1);
    pulse_width("both_pulse_len");
    chk("both_count_after", cnt, 1);

    // async reset mid-pulse
    do_reset(); dc_th = 0; arm();
    strobe_len(10);
    cyc(1);
    chk("mid_pulse_rst", rst, 1);
    rstn = 0;
    #1;
    chk("async_rst", rst, 0);
    chk("async_cause", cause, 0);
    chk("async_count", cnt, 0);
    en = 0; trig = 0;
    cyc(2);
    rstn = 1;
    cyc(3);
    chk("idle_after_rst", rst, 0);
    en = 1;
    strobe_len(10);
    cyc(2);
    chk("no_arm_without_trig", rst, 0);
    trig = 1;
    cyc(1);
    strobe_len(10);
    chk("rearm_rst", rst, 1);
    chk("rearm_cause", cause, 2);
    chk("rearm_count", cnt, 1);

    cyc(8);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
